// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two operands LSB-first through an
// external full-adder cell and assembles the sum and carry-out.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state,    state_nxt;
  logic [CW-1:0]    cnt,      cnt_nxt;
  logic [WIDTH-1:0] opa_sr,   opa_sr_nxt;
  logic [WIDTH-1:0] opb_sr,   opb_sr_nxt;
  logic [WIDTH-1:0] sum_sr,   sum_sr_nxt;
  logic             carry,    carry_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             busy_nxt, done_nxt;
  logic             fa_a_nxt, fa_b_nxt, fa_c_nxt;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opa_sr <= '0;
      opb_sr <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fa_a   <= 1'b0;
      fa_b   <= 1'b0;
      fa_c   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      opa_sr <= opa_sr_nxt;
      opb_sr <= opb_sr_nxt;
      sum_sr <= sum_sr_nxt;
      carry  <= carry_nxt;
      sum    <= sum_nxt;
      cout   <= cout_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      fa_a   <= fa_a_nxt;
      fa_b   <= fa_b_nxt;
      fa_c   <= fa_c_nxt;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    opa_sr_nxt = opa_sr;
    opb_sr_nxt = opb_sr;
    sum_sr_nxt = sum_sr;
    carry_nxt  = carry;
    sum_nxt    = sum;
    cout_nxt   = cout;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    fa_a_nxt   = 1'b0;
    fa_b_nxt   = 1'b0;
    fa_c_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_RUN;
          opa_sr_nxt = opa;
          opb_sr_nxt = opb;
          carry_nxt  = cin;
          cnt_nxt    = '0;
        end
      end
      S_RUN: begin
        sum_sr_nxt = {fa_sum, sum_sr[WIDTH-1:1]};
        carry_nxt  = fa_carry;
        opa_sr_nxt = {1'b0, opa_sr[WIDTH-1:1]};
        opb_sr_nxt = {1'b0, opb_sr[WIDTH-1:1]};
        // Last bit: publish result; counter holds so it never wraps
        if (cnt == LAST_BIT) begin
          state_nxt = S_DONE;
          sum_nxt   = sum_sr_nxt;
          cout_nxt  = fa_carry;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered images of the upcoming state
    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
    if (state_nxt == S_RUN) begin
      fa_a_nxt = opa_sr_nxt[0];
      fa_b_nxt = opb_sr_nxt[0];
      fa_c_nxt = carry_nxt;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural full-adder cell.
module tb_serial_add_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned W1 = W + 1;

  logic         clk = 1'b0;
  logic         resetn, start, cin;
  logic [W-1:0] opa, opb, sum;
  logic         fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic         busy, done, cout;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc_g = 0;
  int last_done_cyc = -1;
  int prev_done_cyc = -1;
  logic [W:0] sb[$];
  logic [W:0] sb_exp;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .opa(opa), .opb(opb), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_g++;

  // Result monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc_g;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        sb_exp = sb.pop_front();
        check("sum", 32'(sum), 32'(sb_exp[W-1:0]));
        check("cout", 32'(cout), 32'(sb_exp[W]));
      end
    end
  end

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c);
    return W1'(a) + W1'(b) + W1'(c);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit want_c, input bit inject);
    int cyc;
    int d0;
    logic [W-1:0] s0;
    logic c0;
    @(negedge clk);
    opa = a; opb = b; cin = c; start = 1'b1;
    sb.push_back(model(a, b, c));
    d0 = done_cnt; s0 = sum; c0 = cout; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (inject && cyc == 3) begin
        start = 1'b1; opa = ~a; opb = 8'h5A; cin = ~c;
      end
      if (inject && cyc == 4) start = 1'b0;
      if (busy) begin
        check("sum_hold", 32'(sum), 32'(s0));
        check("cout_hold", 32'(cout), 32'(c0));
        if (want_c) check("fa_c_run", 32'(fa_c), 32'd1);
      end
    end while (!done && cyc < 40);
    check("latency", 32'(cyc), 32'(W + 1));
    check("fa_in_done", 32'({fa_a, fa_b, fa_c}), 32'd0);
    if (inject) begin
      repeat (W + 4) @(negedge clk);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("idle_after", 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int d0;
    resetn = 1'b0; start = 1'b0; opa = '0; opb = '0; cin = 1'b0;
    #1;
    check("reset_outs", 32'({sum, cout, busy, done, fa_a, fa_b, fa_c}), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    run_op(8'h3C, 8'h81, 1'b0, 1'b0, 1'b1);

    // Abort mid-run at bit 4
    @(negedge clk);
    opa = 8'h55; opb = 8'h22; cin = 1'b0; start = 1'b1;
    n = 0;
    d0 = done_cnt;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (n < 5);
    check("busy_before_abort", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("abort_outs", 32'({sum, cout, busy, done, fa_a, fa_b, fa_c}), 32'd0);
    repeat (W + 2) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    resetn = 1'b1;
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);

    // Start held across two operations
    @(negedge clk);
    d0 = done_cnt;
    opa = 8'h12; opb = 8'h34; cin = 1'b1; start = 1'b1;
    sb.push_back(model(8'h12, 8'h34, 1'b1));
    wait_done("held_done1");
    opa = 8'hA0; opb = 8'h0B; cin = 1'b0;
    sb.push_back(model(8'hA0, 8'h0B, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 10);
    check("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("held_done2");
    repeat (3) @(negedge clk);
    check("held_pulses", 32'(done_cnt - d0), 32'd2);
    check("held_gap", 32'(last_done_cyc - prev_done_cyc), 32'(W + 2));

    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port RESETN, input, 1, the reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port START, input, 1, a request to begin an addition; sampled in IDLE only.
REQ-005 The block SHALL have port OPA, input, WIDTH, the first operand, captured when START is accepted.
REQ-006 The block SHALL have port OPB, input, WIDTH, the second operand, captured when START is accepted.
REQ-007 The block SHALL have port CIN, input, 1, the carry-in, captured when START is accepted.
REQ-008 The block SHALL have port FA_A, output, 1, the operand-A bit driven to the external add full-adder cell.
REQ-009 The block SHALL have port FA_B, output, 1, the operand-B bit driven to the add cell.
REQ-010 The block SHALL have port FA_C, output, 1, the carry bit driven to the add cell.
REQ-011 The block SHALL have port FA_SUM, input, 1, the add cell outadd result.
REQ-012 The block SHALL have port FA_CARRY, input, 1, the add cell outcarry result.
REQ-013 The block SHALL have port BUSY, output, 1, high while an addition is in progress (RUN state).
REQ-014 The block SHALL have port DONE, output, 1, a one-cycle pulse marking SUM and COUT valid.
REQ-015 The block SHALL have port SUM, output, WIDTH, the result register.
REQ-016 The block SHALL have port COUT, output, 1, the final carry-out register.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 The FSM SHALL move from IDLE to RUN on an edge with START=1, and on that edge SHALL load opa_sr<=OPA, opb_sr<=OPB, carry<=CIN and bit counter<=0.
REQ-019 START SHALL be ignored in RUN and DONE, with no effect on operands or the counter.
REQ-020 In RUN, the block SHALL drive FA_A=opa_sr[0], FA_B=opb_sr[0] and FA_C=carry directly from registers, with no combinational path from inputs.
REQ-021 In IDLE and DONE, FA_A, FA_B and FA_C SHALL all be 0.
REQ-022 On each RUN edge, the block SHALL update: sum_sr<={FA_SUM, sum_sr[WIDTH-1:1]}, carry<=FA_CARRY, opa_sr and opb_sr shift right by 1 (MSB filled with 0), counter+1 (LSB-first processing).
REQ-023 On the RUN edge where counter==WIDTH-1, the FSM SHALL move to DONE, and on that same edge SUM<=final sum_sr value and COUT<=FA_CARRY.
REQ-024 DONE SHALL last exactly one cycle with DONE=1, then the FSM SHALL return to IDLE unconditionally.
REQ-025 Latency: with START accepted on edge k, RUN SHALL span edges k+1..k+WIDTH, DONE SHALL be high in the cycle after edge k+WIDTH, and IDLE SHALL follow edge k+WIDTH+1.
REQ-026 The block SHALL produce SUM+COUT*2^WIDTH == OPA+OPB+CIN (modulo 2^(WIDTH+1)), with no overflow flag.
REQ-027 SUM and COUT SHALL hold their last result until the next DONE edge, and SHALL not change during RUN.
REQ-028 The counter SHALL be clog2(WIDTH) bits wide and SHALL not wrap within a run.
REQ-029 A START held continuously SHALL start a new addition on the first IDLE edge after DONE.

Reset
REQ-030 On RESETN=0, the block SHALL immediately (asynchronously) set state=IDLE and clear counter, shift registers and carry to 0.
REQ-031 On RESETN=0, the block SHALL immediately set SUM=0, COUT=0, BUSY=0, DONE=0 and FA_A=FA_B=FA_C=0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse; the first START after RESETN rises SHALL behave as from power-up.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, OPA=0x0F, OPB=0x01, CIN=0 -> DONE exactly 9 cycles after START accepted, SUM=0x10, COUT=0.
REQ-034 The bench SHALL cover: OPA=0xFF, OPB=0x01, CIN=0 -> SUM=0x00, COUT=1 (full carry ripple).
REQ-035 The bench SHALL cover: OPA=0xFF, OPB=0xFF, CIN=1 -> SUM=0xFF, COUT=1, with FA_C=1 in every RUN cycle.
REQ-036 The bench SHALL cover: START pulsed with new operands during RUN -> result is unchanged from the original operands and exactly one DONE pulse occurs.
REQ-037 The bench SHALL cover: RESETN pulled low at RUN bit 4 -> all outputs 0 immediately, no DONE; next START 0x03+0x04 -> SUM=0x07.
REQ-038 The bench SHALL cover: START held high across two operations -> back-to-back results, with DONE pulses 10 cycles apart.
